// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing from the 50 MHz system clock.
// Divides clk down to the pixel tick, runs the h/v raster counters, publishes
// the current coordinate to the renderer and registers sync/blank/colour one
// tick later so everything reaches the DAC pins aligned.
// Optional build macro: TEST_PATTERN_EN replaces rgb_in with eight vertical
// colour bars (white, yellow, cyan, green, magenta, red, blue, black).
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] rgb_in,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        pixel_active,
   output logic        frame_start,
   output logic        vga_clk,
   output logic        vga_h_sync,
   output logic        vga_v_sync,
   output logic        vga_sync,
   output logic        vga_blank,
   output logic [7:0]  vga_red,
   output logic [7:0]  vga_green,
   output logic [7:0]  vga_blue
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   // Sized copies of the timing points so every compare is width-matched.
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_nxt;
   logic             tick;
   logic [9:0]       h;
   logic [9:0]       v;
   logic [23:0]      pix_rgb;
   logic             h_in_sync;
   logic             v_in_sync;

   assign tick = (div == DIV_LAST);

   // Next divider value; wraps on the tick so each coordinate lasts CLK_DIV clks.
   always_comb begin
      div_nxt = div + 1'b1;
      if (tick) div_nxt = '0;
   end

   // Divider and pixel clock; vga_clk tracks div so it falls on every tick edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div     <= '0;
         vga_clk <= 1'b0;
      end else begin
         div     <= div_nxt;
         vga_clk <= (div_nxt >= DIV_HALF);
      end
   end

   // Raster counters; the last pixel of the last line wraps both in one tick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h <= '0;
         v <= '0;
      end else if (tick) begin
         if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) v <= '0;
            else             v <= v + 10'd1;
         end else begin
            h <= h + 10'd1;
         end
      end
   end

   assign pixel_x      = h;
   assign pixel_y      = v;
   assign pixel_active = (h < H_ACT) && (v < V_ACT);
   assign vga_sync     = 1'b0;

   // Gated with the reset pin so nothing pulses while the counters are held at 0.
   assign frame_start  = reset && (h == '0) && (v == '0) && (div == '0);

   assign h_in_sync = (h >= HS_BEGIN) && (h < HS_END);
   assign v_in_sync = (v >= VS_BEGIN) && (v < VS_END);

`ifdef TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
   logic [9:0] bar_idx;

   assign bar_idx = h / BAR_W;

   // Colour-bar source; anything past the eighth bar is blanked anyway.
   always_comb begin
      pix_rgb = 24'h000000;
      case (bar_idx)
         10'd0:   pix_rgb = 24'hFFFFFF;
         10'd1:   pix_rgb = 24'hFFFF00;
         10'd2:   pix_rgb = 24'h00FFFF;
         10'd3:   pix_rgb = 24'h00FF00;
         10'd4:   pix_rgb = 24'hFF00FF;
         10'd5:   pix_rgb = 24'hFF0000;
         10'd6:   pix_rgb = 24'h0000FF;
         default: pix_rgb = 24'h000000;
      endcase
   end
`else
   assign pix_rgb = rgb_in;
`endif

   // Pin stage: one tick behind the counters, colour forced black in blanking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_h_sync <= 1'b1;
         vga_v_sync <= 1'b1;
         vga_blank  <= 1'b0;
         vga_red    <= '0;
         vga_green  <= '0;
         vga_blue   <= '0;
      end else if (tick) begin
         vga_h_sync <= !h_in_sync;
         vga_v_sync <= !v_in_sync;
         vga_blank  <= pixel_active;
         if (pixel_active) begin
            vga_red   <= pix_rgb[23:16];
            vga_green <= pix_rgb[15:8];
            vga_blue  <= pix_rgb[7:0];
         end else begin
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen. The vertical timing
// is shortened (13 lines/frame, v_sync on lines 8..9) so a full frame wrap
// fits in a short run; horizontal timing keeps the real 800-tick line.
// k below = clk rising edges since reset release; tick T = k/2, pins show T-1.
module tb_vga_timing_gen;

   localparam int V_ACT = 6;
   localparam int V_FP  = 2;
   localparam int V_SY  = 2;
   localparam int V_BP  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rgb_mode = 1'b0;
   logic [23:0] rgb_in;
   logic [9:0]  pixel_x, pixel_y;
   logic        pixel_active, frame_start, vga_clk, vga_h_sync, vga_v_sync;
   logic        vga_sync, vga_blank;
   logic [7:0]  vga_red, vga_green, vga_blue;

   vga_timing_gen #(
      .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP)
   ) dut (
      .clk(clk), .reset(reset), .rgb_in(rgb_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_active(pixel_active),
      .frame_start(frame_start), .vga_clk(vga_clk),
      .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .vga_sync(vga_sync),
      .vga_blank(vga_blank), .vga_red(vga_red), .vga_green(vga_green),
      .vga_blue(vga_blue)
   );

   always #10 clk = ~clk;

   // Renderer stand-in: colour encodes the coordinate it was asked for.
   assign rgb_in = rgb_mode ? {pixel_x[7:0], pixel_y[7:0], 8'hA5} : 24'hFFFFFF;

`ifdef TEST_PATTERN_EN
   localparam logic [23:0] C_X0   = 24'hFFFFFF;
   localparam logic [23:0] C_X0Y1 = 24'hFFFFFF;
   localparam logic [23:0] C_X85  = 24'hFFFF00;
   localparam logic [23:0] C_X99  = 24'hFFFF00;
   localparam logic [23:0] C_X600 = 24'h000000;
   localparam logic [23:0] C_X639 = 24'h000000;
`else
   localparam logic [23:0] C_X0   = 24'h0000A5;
   localparam logic [23:0] C_X0Y1 = 24'h0001A5;
   localparam logic [23:0] C_X85  = 24'h5500A5;
   localparam logic [23:0] C_X99  = 24'h6300A5;
   localparam logic [23:0] C_X600 = 24'h5800A5;
   localparam logic [23:0] C_X639 = 24'h7F00A5;
`endif

   typedef enum int {S_X, S_Y, S_ACT, S_FS, S_VCLK, S_HS, S_VS, S_BLANK, S_RGB, S_SYNC} sel_t;
   typedef struct {
      int          n;
      sel_t        sel;
      logic [23:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_neg  = 0;
   int   base   = 0;
   int   checks = 0;
   int   passed = 0;

   task automatic push(input int k, input sel_t s, input logic [23:0] v, input string nm);
      exp_t e;
      e.n = base + k; e.sel = s; e.val = v; e.name = nm;
      q.push_back(e);
   endtask

   function automatic logic [23:0] actual(input sel_t s);
      case (s)
         S_X:     return {14'd0, pixel_x};
         S_Y:     return {14'd0, pixel_y};
         S_ACT:   return {23'd0, pixel_active};
         S_FS:    return {23'd0, frame_start};
         S_VCLK:  return {23'd0, vga_clk};
         S_HS:    return {23'd0, vga_h_sync};
         S_VS:    return {23'd0, vga_v_sync};
         S_BLANK: return {23'd0, vga_blank};
         S_RGB:   return {vga_red, vga_green, vga_blue};
         default: return {23'd0, vga_sync};
      endcase
   endfunction

   // Monitor: on every falling edge pop whatever is due and compare.
   initial begin
      exp_t e;
      logic [23:0] a;
      forever begin
         @(negedge clk);
         n_neg++;
         while (q.size() > 0 && q[0].n <= n_neg) begin
            e = q.pop_front();
            checks++;
            a = actual(e.sel);
            if (e.n < n_neg)
               $display("FAIL %s: entry for edge %0d skipped (now %0d)", e.name, e.n, n_neg);
            else if (a !== e.val)
               $display("FAIL %s: got %h expected %h at edge %0d", e.name, a, e.val, n_neg);
            else
               passed++;
         end
      end
   end

   // Stimulus: drive reset away from the edges and queue expected pin states.
   initial begin
      exp_t e;
      reset = 1'b0;
      rgb_mode = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      base = n_neg + 1;
      push(0, S_HS, 24'd1, "rst_hsync");
      push(0, S_VS, 24'd1, "rst_vsync");
      push(0, S_BLANK, 24'd0, "rst_blank");
      push(0, S_RGB, 24'd0, "rst_rgb");
      push(0, S_VCLK, 24'd0, "rst_vclk");
      push(0, S_X, 24'd0, "rst_x");
      push(0, S_Y, 24'd0, "rst_y");
      push(0, S_FS, 24'd0, "rst_fs_low");
      push(0, S_SYNC, 24'd0, "rst_sync");

      @(posedge clk);
      #2;
      reset = 1'b1;
      rgb_mode = 1'b1;
      base = n_neg + 1;
      push(0, S_FS, 24'd1, "fs_on_release");
      push(0, S_X, 24'd0, "x_k0");
      push(0, S_Y, 24'd0, "y_k0");
      push(0, S_VCLK, 24'd0, "vclk_k0");
      push(0, S_HS, 24'd1, "hs_k0");
      push(0, S_BLANK, 24'd0, "blank_k0");
      push(1, S_FS, 24'd0, "fs_one_clk");
      push(1, S_VCLK, 24'd1, "vclk_k1");
      push(1, S_X, 24'd0, "x_k1_hold");
      push(2, S_VCLK, 24'd0, "vclk_k2");
      push(2, S_X, 24'd1, "x_k2");
      push(2, S_BLANK, 24'd1, "blank_first_px");
      push(2, S_RGB, C_X0, "rgb_x0");
      push(3, S_X, 24'd1, "x_k3_hold");
      push(3, S_VCLK, 24'd1, "vclk_k3");
      push(172, S_RGB, C_X85, "rgb_x85");
      push(200, S_X, 24'd100, "x_100");
      push(200, S_ACT, 24'd1, "act_x100");
      push(200, S_RGB, C_X99, "rgb_x99");
      push(201, S_X, 24'd100, "x_100_hold");
      push(1202, S_RGB, C_X600, "rgb_x600");
      push(1278, S_X, 24'd639, "x_639");
      push(1278, S_ACT, 24'd1, "act_x639");
      push(1280, S_X, 24'd640, "x_640");
      push(1280, S_ACT, 24'd0, "act_x640");
      push(1280, S_BLANK, 24'd1, "blank_x639");
      push(1280, S_RGB, C_X639, "rgb_x639");
      push(1282, S_BLANK, 24'd0, "blank_x640");
      push(1282, S_RGB, 24'd0, "rgb_x640_black");
      push(1312, S_X, 24'd656, "x_656");
      push(1312, S_HS, 24'd1, "hs_before");
      push(1314, S_HS, 24'd0, "hs_fall");
      push(1504, S_HS, 24'd0, "hs_last");
      push(1506, S_HS, 24'd1, "hs_rise");
      push(1598, S_X, 24'd799, "x_799");
      push(1598, S_Y, 24'd0, "y_line0");
      push(1600, S_X, 24'd0, "x_wrap");
      push(1600, S_Y, 24'd1, "y_line1");
      push(1600, S_FS, 24'd0, "fs_not_line1");
      push(1602, S_BLANK, 24'd1, "blank_line1");
      push(1602, S_RGB, C_X0Y1, "rgb_x0y1");
      push(2914, S_HS, 24'd0, "hs_line1");
      push(8002, S_BLANK, 24'd1, "blank_last_active_line");
      push(9622, S_Y, 24'd6, "y_6");
      push(9622, S_ACT, 24'd0, "act_vblank");
      push(9622, S_BLANK, 24'd0, "blank_vblank");
      push(9622, S_RGB, 24'd0, "rgb_vblank_black");
      push(12800, S_X, 24'd0, "x_line8");
      push(12800, S_Y, 24'd8, "y_8");
      push(12800, S_VS, 24'd1, "vs_before");
      push(12802, S_VS, 24'd0, "vs_fall");
      push(16000, S_VS, 24'd0, "vs_last");
      push(16002, S_VS, 24'd1, "vs_rise");
      push(20798, S_X, 24'd799, "x_last");
      push(20798, S_Y, 24'd12, "y_last");
      push(20798, S_FS, 24'd0, "fs_before_wrap");
      push(20799, S_FS, 24'd0, "fs_div1");
      push(20800, S_X, 24'd0, "x_frame_wrap");
      push(20800, S_Y, 24'd0, "y_frame_wrap");
      push(20800, S_FS, 24'd1, "fs_frame2");
      push(20800, S_BLANK, 24'd0, "blank_last_px");
      push(20801, S_FS, 24'd0, "fs_frame2_end");
      push(20802, S_BLANK, 24'd1, "blank_frame2");
      push(20802, S_RGB, C_X0, "rgb_frame2");
      push(23800, S_X, 24'd700, "x_700");
      push(23800, S_Y, 24'd1, "y_1_frame2");
      push(23800, S_HS, 24'd0, "hs_mid_pulse");

      // Reset mid-line while h_sync is low; effect must show before any clk edge.
      repeat (23801) @(posedge clk);
      #2;
      base = n_neg + 1;
      push(0, S_X, 24'd0, "mid_rst_x");
      push(0, S_Y, 24'd0, "mid_rst_y");
      push(0, S_HS, 24'd1, "mid_rst_hs");
      push(0, S_VS, 24'd1, "mid_rst_vs");
      push(0, S_BLANK, 24'd0, "mid_rst_blank");
      push(0, S_RGB, 24'd0, "mid_rst_rgb");
      push(0, S_VCLK, 24'd0, "mid_rst_vclk");
      push(0, S_FS, 24'd0, "mid_rst_fs");
      reset = 1'b0;

      @(posedge clk);
      #2;
      reset = 1'b1;
      base = n_neg + 1;
      push(0, S_FS, 24'd1, "fs_rerelease");
      push(0, S_X, 24'd0, "x_rerelease");
      push(1, S_FS, 24'd0, "fs_rerelease_end");
      push(1, S_VCLK, 24'd1, "vclk_rerelease");
      push(2, S_X, 24'd1, "x_restart");
      push(2, S_BLANK, 24'd1, "blank_restart");
      push(2, S_RGB, C_X0, "rgb_restart");
      push(2, S_HS, 24'd1, "hs_restart");
      push(1314, S_HS, 24'd0, "hs_fall_restart");
      push(1506, S_HS, 24'd1, "hs_rise_restart");

      repeat (1512) @(posedge clk);
      #2;
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         $display("FAIL %s: never sampled (due edge %0d, now %0d)", e.name, e.n, n_neg);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Safety net so the run always ends with a summary.
   initial begin
      #2000000;
      checks++;
      $display("FAIL watchdog: run still active at time %0t, required to be finished", $time);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
